bus_grant_arbiter: RTL
======================

// Module: bus_grant_arbiter
// PURPOSE
//  Sequential arbiter that decides which datapath source drives the shared bus.
//  Takes per-source drive requests and issues a registered one-hot grant word.
//  The grant word feeds encoder_32_to_5 directly; the encoder turns it into the bus-mux select.
//  Guarantees the encoder sees either exactly one hot bit or all zeros; all zeros encodes to 31 (no driver).
// PARAMETERS
//  NUM_SRC     24  number of bus sources; index map comes from bus_pkg; must be <= 32
//  TURNAROUND  1   idle cycles (0 or 1) with grant = 0 between two owners
//  MAX_HOLD    0   maximum consecutive grant cycles per owner; 0 = unlimited; otherwise 1..255
// PORTS
//  clk       in   1        system clock, rising edge
//  clr_n     in   1        asynchronous, active-low reset
//  req       in   NUM_SRC  drive requests, one bit per source
//  release   in   1        current owner finished; drop the grant at the next edge
//  grant     out  32       registered one-hot bus-source select, to encoder_32_to_5
//  busy      out  1        1 while grant != 0
//  timeout   out  1        1-cycle pulse when an owner is revoked by MAX_HOLD
// BEHAVIOUR
//  Reset: asynchronous on clr_n=0.
//   - Outputs: grant=0, busy=0, timeout=0.
//   - State: state=IDLE, hold_cnt=0, rr_ptr=NUM_SRC-1, so source 0 has top priority first.
//  All outputs are registered; no combinational path from any input to any output.
//  States:
//   - IDLE: if req!=0, pick the winner, load grant with 1<<win and go to OWN; else stay.
//   - OWN: grant is held stable. End of ownership happens at the edge where any of these is seen:
//     release=1, req[owner]=0, or hold_cnt==MAX_HOLD-1 (only when MAX_HOLD!=0).
//   - At end of ownership: grant=0 and rr_ptr=owner.
//     If TURNAROUND=1, go to GAP.
//     If TURNAROUND=0, re-arbitrate in the same edge: go to OWN with the new winner, or to IDLE if req=0.
//   - GAP: grant=0 for exactly one cycle, then go to IDLE. Requests seen in GAP are ignored.
//  Arbitration is round-robin.
//   - Search order is rr_ptr+1, rr_ptr+2, ... modulo NUM_SRC; the first set req bit wins.
//   - Wrap-around: after owner NUM_SRC-1, the search starts at 0.
//   - The released owner may win again only if it is the sole requester.
//  Latency: req sampled at edge n gives grant at edge n (visible in the following cycle). Minimum 1 cycle.
//  hold_cnt:
//   - Cleared on entry to OWN; +1 per OWN cycle; 8-bit, saturates at 255.
//   - timeout=1 for exactly the cycle after a MAX_HOLD revocation. release on the same edge takes precedence: timeout=0.
//  Width rules:
//   - grant[31:NUM_SRC] are tied to 0.
//   - req is zero-extended internally to 32 bits.
//  Invariants:
//   - popcount(grant) <= 1 at all times.
//   - busy == |grant.
//  Mid-operation reset: grant drops asynchronously; no partial grant survives.
// STRUCTURE
//  bus_pkg (shared):
//   - NUM_BUS_SRC=24.
//   - Source index constants: SRC_R0..SRC_R15=0..15, SRC_HI=16, SRC_LO=17, SRC_ZHI=18, SRC_ZLO=19,
//     SRC_PC=20, SRC_MDR=21, SRC_INPORT=22, SRC_C=23.
//   - BUS_NO_DRIVER=5'd31.
//   - State encoding typedef {IDLE, OWN, GAP}.
//  Sub-module rr_priority_pick (combinational): inputs req and rr_ptr; outputs win_idx[4:0] and win_valid.
//   Implemented as a rotated priority search.
//  Top level holds the FSM, the hold counter, rr_ptr and the grant register.
// TESTING
//  T1 reset: clr_n=0 with req=24'hFFFFFF -> grant=0, busy=0. Release clr_n, req=24'h000001 -> after 1 edge grant=32'h00000001, busy=1.
//  T2 round-robin: req=24'h000005 -> grant=32'h1; release=1 -> GAP cycle with grant=0 -> grant=32'h4 (bit 2), not bit 0.
//  T3 wrap: owner=23 (grant=32'h00800000), req=24'h800001, release=1 -> after GAP, grant=32'h00000001.
//  T4 timeout: MAX_HOLD=4, req=24'h000020 held, no release -> grant=32'h20 for exactly 4 cycles, then grant=0 and timeout=1 for 1 cycle.
//  T5 async reset mid-OWN: clr_n=0 between edges -> grant=0 immediately. After release with req=24'h800001 -> grant=32'h1 (pointer reset).
//  T6 random req/release for 10k cycles:
//   - popcount(grant)<=1 and grant[31:24]==0 on every cycle.
//   - encoder_32_to_5 output != 31 whenever busy=1.
//   - A requester held high is granted within NUM_SRC*(MAX_HOLD+TURNAROUND) cycles (no starvation).

Source files
------------

// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_pkg
// Description : Shared bus definitions: source count, source index map,
//               the "no driver" encoder code, arbiter state encoding and a
//               round-robin index helper.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

    // Number of sources that can drive the shared bus
    localparam int NUM_BUS_SRC = 24;

    // Source index map (bit position in the grant word)
    localparam logic [4:0] SRC_R0     = 5'd0;
    localparam logic [4:0] SRC_R1     = 5'd1;
    localparam logic [4:0] SRC_R2     = 5'd2;
    localparam logic [4:0] SRC_R3     = 5'd3;
    localparam logic [4:0] SRC_R4     = 5'd4;
    localparam logic [4:0] SRC_R5     = 5'd5;
    localparam logic [4:0] SRC_R6     = 5'd6;
    localparam logic [4:0] SRC_R7     = 5'd7;
    localparam logic [4:0] SRC_R8     = 5'd8;
    localparam logic [4:0] SRC_R9     = 5'd9;
    localparam logic [4:0] SRC_R10    = 5'd10;
    localparam logic [4:0] SRC_R11    = 5'd11;
    localparam logic [4:0] SRC_R12    = 5'd12;
    localparam logic [4:0] SRC_R13    = 5'd13;
    localparam logic [4:0] SRC_R14    = 5'd14;
    localparam logic [4:0] SRC_R15    = 5'd15;
    localparam logic [4:0] SRC_HI     = 5'd16;
    localparam logic [4:0] SRC_LO     = 5'd17;
    localparam logic [4:0] SRC_ZHI    = 5'd18;
    localparam logic [4:0] SRC_ZLO    = 5'd19;
    localparam logic [4:0] SRC_PC     = 5'd20;
    localparam logic [4:0] SRC_MDR    = 5'd21;
    localparam logic [4:0] SRC_INPORT = 5'd22;
    localparam logic [4:0] SRC_C      = 5'd23;

    // Encoder output when the grant word is all zeros
    localparam logic [4:0] BUS_NO_DRIVER = 5'd31;

    // Arbiter state encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Index that lies 'step' positions after 'base', modulo num_src.
    // base < num_src and step <= num_src, so one subtraction suffices.
    function automatic logic [4:0] rr_step(input logic [4:0] base,
                                           input int         step,
                                           input int         num_src);
        int sum;
        sum = int'({27'd0, base}) + step;
        if (sum >= num_src) begin
            sum = sum - num_src;
        end
        return sum[4:0];
    endfunction

endpackage : bus_pkg
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_pick
// Description : Combinational round-robin pick. Searches req starting one
//               position after rr_ptr and wrapping modulo NUM_SRC; the first
//               set bit wins. rr_ptr itself is visited last, so the previous
//               owner only wins when it is the sole requester.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_pick
    import bus_pkg::*;
#(
    parameter int NUM_SRC = NUM_BUS_SRC
) (
    input  logic [31:0] req,
    input  logic [4:0]  rr_ptr,
    output logic [4:0]  win_idx,
    output logic        win_valid
);

    logic [4:0] w_cand;

    // Rotated priority search: candidates rr_ptr+1 .. rr_ptr+NUM_SRC
    always_comb begin
        win_idx   = 5'd0;
        win_valid = 1'b0;
        w_cand    = 5'd0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            w_cand = rr_step(rr_ptr, k, NUM_SRC);
            if (!win_valid && req[w_cand]) begin
                win_valid = 1'b1;
                win_idx   = w_cand;
            end
        end
    end

endmodule : rr_priority_pick
`default_nettype wire

// File: rtl/bus_grant_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_grant_arbiter
// Description : Round-robin owner arbiter for the shared datapath bus.
//               Issues a registered one-hot grant word (or all zeros) that
//               feeds encoder_32_to_5 directly. Supports an optional idle
//               turnaround cycle between owners and an optional hold limit
//               that revokes an owner and pulses timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_grant_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_SRC    = NUM_BUS_SRC,  // <= 32
    parameter int TURNAROUND = 1,            // 0 or 1 idle cycles between owners
    parameter int MAX_HOLD   = 0             // 0 = unlimited, else 1..255
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic [NUM_SRC-1:0] req,
    // "release" is a reserved word in SystemVerilog, hence this name
    input  logic               owner_release,
    output logic [31:0]        grant,
    output logic               busy,
    output logic               timeout
);

    localparam logic [NUM_SRC-1:0] GRANT_LSB = NUM_SRC'(1);
    localparam logic [4:0]         RR_RESET  = 5'(NUM_SRC - 1);
    localparam bit                 USE_GAP   = (TURNAROUND != 0);
    localparam bit                 HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [7:0]         HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

    // Registered state
    state_t             r_state;
    logic [NUM_SRC-1:0] r_grant;
    logic [4:0]         r_owner;
    logic [4:0]         r_rr_ptr;
    logic [7:0]         r_hold_cnt;
    logic               r_busy;
    logic               r_timeout;

    // Next-state values
    state_t             w_state_nxt;
    logic [NUM_SRC-1:0] w_grant_nxt;
    logic [4:0]         w_owner_nxt;
    logic [4:0]         w_rr_ptr_nxt;
    logic [7:0]         w_hold_nxt;
    logic               w_timeout_nxt;

    // Arbitration and end-of-ownership terms
    logic [31:0]        w_req_ext;
    logic [4:0]         w_pick_ptr;
    logic [4:0]         w_win_idx;
    logic               w_win_valid;
    logic               w_hold_hit;
    logic               w_own_end;
    logic [7:0]         w_hold_inc;

    // Requests are handled as a 32-bit word; unused sources read as zero
    generate
        if (NUM_SRC < 32) begin : g_req_pad
            assign w_req_ext = {{(32 - NUM_SRC){1'b0}}, req};
        end else begin : g_req_full
            assign w_req_ext = req;
        end
    endgenerate

    // While owning, the pointer that will be in force after this owner is
    // the owner itself, so a same-edge re-arbitration searches from there.
    assign w_pick_ptr = (r_state == OWN) ? r_owner : r_rr_ptr;

    rr_priority_pick #(
        .NUM_SRC   (NUM_SRC)
    ) u_pick (
        .req       (w_req_ext),
        .rr_ptr    (w_pick_ptr),
        .win_idx   (w_win_idx),
        .win_valid (w_win_valid)
    );

    assign w_hold_hit = HOLD_EN && (r_hold_cnt == HOLD_LAST);
    assign w_own_end  = owner_release || !w_req_ext[r_owner] || w_hold_hit;
    assign w_hold_inc = (r_hold_cnt == 8'hFF) ? r_hold_cnt : (r_hold_cnt + 8'd1);

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_owner_nxt   = r_owner;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_hold_nxt    = r_hold_cnt;
        w_timeout_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_win_valid) begin
                    w_state_nxt = OWN;
                    w_grant_nxt = GRANT_LSB << w_win_idx;
                    w_owner_nxt = w_win_idx;
                    w_hold_nxt  = 8'd0;
                end
            end
            OWN: begin
                w_hold_nxt = w_hold_inc;
                if (w_own_end) begin
                    w_grant_nxt   = '0;
                    w_rr_ptr_nxt  = r_owner;
                    // An explicit release on the same edge is not a timeout
                    w_timeout_nxt = w_hold_hit && !owner_release;
                    if (USE_GAP) begin
                        w_state_nxt = GAP;
                    end else if (w_win_valid) begin
                        w_state_nxt = OWN;
                        w_grant_nxt = GRANT_LSB << w_win_idx;
                        w_owner_nxt = w_win_idx;
                        w_hold_nxt  = 8'd0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            GAP: begin
                // Requests are deliberately ignored for this cycle
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // State, pointer, counter and output registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_owner    <= 5'd0;
            r_rr_ptr   <= RR_RESET;
            r_hold_cnt <= 8'd0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_busy     <= |w_grant_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    // Grant bits above the last source are permanently zero
    generate
        if (NUM_SRC < 32) begin : g_grant_pad
            assign grant = {{(32 - NUM_SRC){1'b0}}, r_grant};
        end else begin : g_grant_full
            assign grant = r_grant;
        end
    endgenerate

    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule : bus_grant_arbiter
`default_nettype wire
